// File: rtl/md_unit_pipe.sv
// Multiply/divide unit owning HI/LO; MULT_CYCLES/DIV_CYCLES busy cycles, then a one-cycle done pulse.
// No backpressure: start while busy is dropped. MD_ACCUM_EN enables the MADD/MSUB (op 1xx) accumulate ops.
module md_unit_pipe #(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2:0]          op_q;
  logic                op_legal, launch, finish;
  logic [2*DATA_W-1:0] a_ext, b_ext, prod, div_res, result;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag, q_mag, r_mag, quo, rem;

`ifdef MD_ACCUM_EN
  logic [2*DATA_W-1:0] base_q;
`endif

  always_comb begin
`ifdef MD_ACCUM_EN
    op_legal = 1'b1;
`else
    op_legal = ~op[2];
`endif
    launch    = (state == IDLE) && start && !flush && op_legal;
    finish    = (state == RUN) && !flush && (cnt == '0);
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = RUN;
      RUN:  if (flush || finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand extension to 2*DATA_W makes one multiplier serve both signednesses.
  always_comb begin
    a_ext = op_q[0] ? {{DATA_W{1'b0}}, a_q} : {{DATA_W{a_q[DATA_W-1]}}, a_q};
    b_ext = op_q[0] ? {{DATA_W{1'b0}}, b_q} : {{DATA_W{b_q[DATA_W-1]}}, b_q};
    prod  = a_ext * b_ext;
  end

  // Sign-magnitude divide; MIN / -1 falls out naturally as quotient MIN, remainder 0.
  always_comb begin
    a_neg   = ~op_q[0] & a_q[DATA_W-1];
    b_neg   = ~op_q[0] & b_q[DATA_W-1];
    a_mag   = a_neg ? -a_q : a_q;
    b_mag   = b_neg ? -b_q : b_q;
    q_mag   = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag   = (b_mag == '0) ? '0 : a_mag % b_mag;
    quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;
    div_res = (b_q == '0) ? {a_q, {DATA_W{1'b1}}} : {rem, quo};
  end

  always_comb begin
`ifdef MD_ACCUM_EN
    if (op_q[2])      result = op_q[1] ? base_q - prod : base_q + prod;
    else if (op_q[1]) result = div_res;
    else              result = prod;
`else
    result = (op_q[1] && !op_q[2]) ? div_res : prod;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (launch) begin
      cnt  <= (op[1] && !op[2]) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end else if (state == RUN && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef MD_ACCUM_EN
  // Accumulator base includes any MTHI/MTLO issued in the launch cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      base_q <= '0;
    else if (launch) base_q <= {wr_hi ? wr_data : hi, wr_lo ? wr_data : lo};
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        {hi, lo} <= result;
      end else if (state == IDLE) begin
        if (wr_hi) hi <= wr_data;
        if (wr_lo) lo <= wr_data;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_unit_pipe.sv
// Directed-vector bench for md_unit_pipe at default parameters.
module tb_md_unit_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0, wr_data = '0;
  logic        wr_hi = 1'b0, wr_lo = 1'b0, flush = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  md_unit_pipe dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int len,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({nm, " busy_len"}, 64'(n), 64'(len));
    check({nm, " done"}, 64'(done), 64'd1);
    check({nm, " hi"}, 64'(hi), 64'(eh));
    check({nm, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({nm, " done_fall"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{"mult_neg",   3'b000, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{"multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"div_neg",    3'b010, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"divu_zero",  3'b011, 32'd5,        32'd0,        10, 32'd5,        32'hFFFFFFFF};
    vecs[4] = '{"div_ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0,        32'h80000000};
    vecs[5] = '{"divu_plain", 3'b011, 32'd100,      32'd7,        10, 32'd2,        32'd14};
    vecs[6] = '{"div_negdiv", 3'b010, 32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{"mult_m1",    3'b000, 32'd7,        32'hFFFFFFFF, 5,  32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[8] = '{"multu_carry",3'b001, 32'h00010000, 32'h00010000, 5,  32'd1,        32'd0};
    vecs[9] = '{"div_zero_s", 3'b010, 32'hFFFFFFF9, 32'd0,        10, 32'hFFFFFFF9, 32'hFFFFFFFF};

    #12;
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].hi, vecs[i].lo);

    // Simultaneous MTHI/MTLO, then MTHI alone.
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000AAAA;
    @(negedge clk);
    wr_lo = 1'b0; wr_data = 32'h00001234;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234);
    check("mtlo lo", 64'(lo), 64'hAAAA);

    // Flush during the second busy cycle.
    start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("flush busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    check("flush hi", 64'(hi), 64'h1234);
    check("flush lo", 64'(lo), 64'hAAAA);
    @(negedge clk);
    check("flush done_late", 64'(done), 64'd0);

    // Restart mid-run and MTLO while busy are both ignored.
    start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd5;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000DEAD;
    @(negedge clk);
    wr_lo = 1'b0;
    check("mtlo_busy lo", 64'(lo), 64'hAAAA);
    n = 3;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("restart busy_len", 64'(n), 64'd5);
    check("restart done", 64'(done), 64'd1);
    check("restart hi", 64'(hi), 64'd0);
    check("restart lo", 64'(lo), 64'd6);
    @(negedge clk);
    check("restart no_second_op", 64'(busy), 64'd0);

    // Async reset in the middle of a divide.
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'd10;
    @(negedge clk);
    wr_lo = 1'b0;
    check("acc_base lo", 64'(lo), 64'd10);
`ifdef MD_ACCUM_EN
    run_op("madd", 3'b100, 32'd3, 32'd4, 5, 32'd0, 32'd22);
    run_op("msubu", 3'b111, 32'd1, 32'd23, 5, 32'hFFFFFFFF, 32'hFFFFFFFF);
`else
    start = 1'b1; op = 3'b100; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    check("illegal busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("illegal busy_late", 64'(busy), 64'd0);
    check("illegal done", 64'(done), 64'd0);
    check("illegal hi", 64'(hi), 64'd0);
    check("illegal lo", 64'(lo), 64'd10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
